// File: rtl/hv_sw_serial_rx_if.sv
// hv_sw_serial_rx_if: HV switch serial link lines plus the receiver's decoded outputs.
interface hv_sw_serial_rx_if #(
    parameter int N_CH  = 16,
    parameter int CNT_W = 6
);
    logic            hv_sw_clr;
    logic            hv_sw_le;
    logic            hv_sw_clk;
    logic            hv_sw_dout;
    logic [N_CH-1:0] sw_state;
    logic            sw_valid;
    logic            frame_err;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]     frame_cnt;
    modport master (
        output hv_sw_clr, hv_sw_le, hv_sw_clk, hv_sw_dout,
        input  sw_state, sw_valid, frame_err, bit_cnt, frame_cnt
    );
    modport slave (
        input  hv_sw_clr, hv_sw_le, hv_sw_clk, hv_sw_dout,
        output sw_state, sw_valid, frame_err, bit_cnt, frame_cnt
    );
endinterface

// File: rtl/hv_sw_serial_rx.sv
// hv_sw_serial_rx: oversamples the CLR/LE/CLK/DOUT link, shifts DOUT on CLK rise and latches the word on LE rise.
module hv_sw_serial_rx #(
    parameter int N_CH      = 16,
    parameter int CNT_W     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic          clk_in,
    input logic          reset,
    hv_sw_serial_rx_if.slave link
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, CLEAR} state_e;
    state_e           state_q;
    logic [3:0]       s1_q, s2_q;
    logic [1:0]       s3_q;
    logic [N_CH-1:0]  sreg_q, sreg_d, sw_state_q;
    logic             sw_valid_q, frame_err_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]      frame_cnt_q;
    logic             clr_s, le_ev, clk_ev, dout_s;
    // synchronizer lanes: [3]=CLR [2]=LE [1]=CLK [0]=DOUT
    assign clr_s     = s2_q[3];
    assign le_ev     = s2_q[2] & ~s3_q[1];
    assign clk_ev    = s2_q[1] & ~s3_q[0];
    assign dout_s    = s2_q[0];
    assign sreg_d    = MSB_FIRST ? {sreg_q[N_CH-2:0], dout_s} : {dout_s, sreg_q[N_CH-1:1]};
    assign bit_cnt_d = &bit_cnt_q ? bit_cnt_q : bit_cnt_q + 1'b1;
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            sreg_q      <= '0;
            sw_state_q  <= '0;
            sw_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            s1_q       <= {link.hv_sw_clr, link.hv_sw_le, link.hv_sw_clk, link.hv_sw_dout};
            s2_q       <= s1_q;
            s3_q       <= s2_q[2:1];
            sw_valid_q <= 1'b0;
            if (clr_s) begin
                state_q    <= CLEAR;
                sreg_q     <= '0;
                sw_state_q <= '0;
                bit_cnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE, SHIFT: begin
                        if (clk_ev) begin
                            sreg_q    <= sreg_d;
                            bit_cnt_q <= bit_cnt_d;
                        end
                        // a CLK event in the same cycle as LE is shifted before the latch
                        state_q <= le_ev ? LATCH : (clk_ev ? SHIFT : state_q);
                    end
                    LATCH: begin
                        sw_state_q  <= sreg_q;
                        sw_valid_q  <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        frame_err_q <= bit_cnt_q != CNT_W'(N_CH);
                        bit_cnt_q   <= '0;
                        state_q     <= IDLE;
                    end
                    CLEAR: state_q <= IDLE;
                endcase
            end
        end
    end
    assign link.sw_state  = sw_state_q;
    assign link.sw_valid  = sw_valid_q;
    assign link.frame_err = frame_err_q;
    assign link.bit_cnt   = bit_cnt_q;
    assign link.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_hv_sw_serial_rx.sv
// tb_hv_sw_serial_rx: directed link frames against a frame-level scoreboard of expected latches and clears.
module tb_hv_sw_serial_rx;
    logic clk_in;
    logic reset;
    int   cyc;
    int   n_chk, n_err;
    hv_sw_serial_rx_if bus ();
    hv_sw_serial_rx dut (.clk_in(clk_in), .reset(reset), .link(bus));
    typedef struct {int due; logic [15:0] word; logic err; logic clr;} ev_t;
    ev_t         pend[$];
    bit          hist[$];
    int          nbits;
    logic [15:0] m_state;
    logic        m_err;
    logic [15:0] m_cnt;
    logic        exp_v;
    int          pi;
    int          le_c, dut_v_cyc;
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    // the word a latch must present: the most recent 16 bits since reset/clear, newest in bit 0
    function automatic logic [15:0] last16();
        logic [15:0] w = '0;
        for (int k = 0; k < 16; k++)
            if (hist.size() > k) w[k] = hist[hist.size()-1-k];
        return w;
    endfunction
    task automatic send_bit(input bit b, input int h);
        bus.hv_sw_dout = b;
        repeat (h) tick();
        bus.hv_sw_clk = 1'b1;
        hist.push_back(b);
        nbits++;
        repeat (h) tick();
        bus.hv_sw_clk = 1'b0;
    endtask
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], 4);
    endtask
    task automatic pulse_le();
        bus.hv_sw_le = 1'b1;
        pend.push_back('{due: cyc + 4, word: last16(), err: nbits != 16, clr: 1'b0});
        le_c  = cyc;
        nbits = 0;
        repeat (4) tick();
        bus.hv_sw_le = 1'b0;
        repeat (4) tick();
    endtask
    task automatic last_bit_with_le(input bit b);
        bus.hv_sw_dout = b;
        repeat (4) tick();
        bus.hv_sw_clk = 1'b1;
        bus.hv_sw_le  = 1'b1;
        hist.push_back(b);
        nbits++;
        pend.push_back('{due: cyc + 4, word: last16(), err: nbits != 16, clr: 1'b0});
        nbits = 0;
        repeat (4) tick();
        bus.hv_sw_clk = 1'b0;
        bus.hv_sw_le  = 1'b0;
        repeat (4) tick();
    endtask
    task automatic raise_clr();
        bus.hv_sw_clr = 1'b1;
        pend.push_back('{due: cyc + 3, word: 16'h0, err: 1'b0, clr: 1'b1});
        hist.delete();
        nbits = 0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.hv_sw_clk  = 1'b0;
        bus.hv_sw_le   = 1'b0;
        bus.hv_sw_dout = 1'b0;
        bus.hv_sw_clr  = 1'b0;
        hist.delete();
        nbits = 0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_state"}, bus.sw_state, 0);
        chk({nm, "_valid"}, bus.sw_valid, 0);
        chk({nm, "_err"}, bus.frame_err, 0);
        chk({nm, "_bitcnt"}, bus.bit_cnt, 0);
        chk({nm, "_fcnt"}, bus.frame_cnt, 0);
    endtask
    // cycle-accurate compare: outputs follow the scoreboard's due events exactly
    always @(negedge clk_in) begin
        if (reset) begin
            pend.delete();
            m_state = '0;
            m_err   = 1'b0;
            m_cnt   = '0;
        end else begin
            exp_v = 1'b0;
            pi    = 0;
            while (pi < pend.size()) begin
                if (pend[pi].due == cyc) begin
                    if (pend[pi].clr) m_state = '0;
                    else begin
                        exp_v   = 1'b1;
                        m_state = pend[pi].word;
                        m_err   = pend[pi].err;
                        m_cnt   = m_cnt + 16'd1;
                    end
                    pend.delete(pi);
                end else pi++;
            end
            if (bus.sw_valid) dut_v_cyc = cyc;
            chk("cyc_valid", bus.sw_valid, exp_v);
            chk("cyc_state", bus.sw_state, m_state);
            chk("cyc_err", bus.frame_err, m_err);
            chk("cyc_fcnt", bus.frame_cnt, m_cnt);
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
    initial begin
        reset = 1'b1;
        bus.hv_sw_clr = 1'b0; bus.hv_sw_le = 1'b0; bus.hv_sw_clk = 1'b0; bus.hv_sw_dout = 1'b0;
        tick();
        // T1 reset with toggling lines
        for (int i = 0; i < 5; i++) begin
            {bus.hv_sw_clr, bus.hv_sw_le, bus.hv_sw_clk, bus.hv_sw_dout} = 4'($urandom);
            tick();
            chk("rst_valid", bus.sw_valid, 0);
            chk("rst_state", bus.sw_state, 0);
        end
        {bus.hv_sw_clr, bus.hv_sw_le, bus.hv_sw_clk, bus.hv_sw_dout} = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_zero("t1");
        // T2 nominal frame, then LE with zero bits
        send_bits(16'hA5C3, 16);
        chk("t2_bitcnt16", bus.bit_cnt, 16);
        pulse_le();
        chk("t2_state", bus.sw_state, 16'hA5C3);
        chk("t2_err", bus.frame_err, 0);
        chk("t2_fcnt", bus.frame_cnt, 1);
        chk("t2_bitcnt", bus.bit_cnt, 0);
        chk("t2_latency", dut_v_cyc - le_c, 4);
        pulse_le();
        chk("t2z_state", bus.sw_state, 16'hA5C3);
        chk("t2z_err", bus.frame_err, 1);
        chk("t2z_fcnt", bus.frame_cnt, 2);
        // T3 overrun then a clean frame
        send_bits(16'h3, 2);
        send_bits(16'h1234, 16);
        pulse_le();
        chk("t3o_state", bus.sw_state, 16'h1234);
        chk("t3o_err", bus.frame_err, 1);
        send_bits(16'hFFFF, 16);
        pulse_le();
        chk("t3_state", bus.sw_state, 16'hFFFF);
        chk("t3_err", bus.frame_err, 0);
        chk("t3_fcnt", bus.frame_cnt, 4);
        // T4 clear mid-frame, events ignored during clear
        send_bits(16'hAB, 8);
        repeat (4) tick();
        chk("t4_bitcnt8", bus.bit_cnt, 8);
        raise_clr();
        repeat (4) tick();
        chk("t4_state", bus.sw_state, 0);
        chk("t4_bitcnt", bus.bit_cnt, 0);
        bus.hv_sw_clk = 1'b1; repeat (2) tick(); bus.hv_sw_clk = 1'b0; repeat (2) tick();
        bus.hv_sw_le  = 1'b1; repeat (2) tick(); bus.hv_sw_le  = 1'b0; repeat (4) tick();
        bus.hv_sw_clr = 1'b0;
        repeat (4) tick();
        chk("t4_fcnt_hold", bus.frame_cnt, 4);
        chk("t4_bitcnt_ign", bus.bit_cnt, 0);
        send_bits(16'h0F0F, 16);
        pulse_le();
        chk("t4_frame", bus.sw_state, 16'h0F0F);
        chk("t4_err", bus.frame_err, 0);
        // T5 LE with 16th CLK, then CLR+LE together
        send_bits(16'h8421 >> 1, 15);
        last_bit_with_le(1'b1);
        chk("t5_state", bus.sw_state, 16'h8421);
        chk("t5_err", bus.frame_err, 0);
        chk("t5_fcnt", bus.frame_cnt, 6);
        send_bits(16'h15, 5);
        raise_clr();
        bus.hv_sw_le = 1'b1;
        repeat (4) tick();
        bus.hv_sw_le = 1'b0;
        repeat (3) tick();
        bus.hv_sw_clr = 1'b0;
        repeat (4) tick();
        chk("t5c_fcnt", bus.frame_cnt, 6);
        chk("t5c_state", bus.sw_state, 0);
        // T6 reset mid-frame
        send_bits(16'h2AA, 10);
        do_reset();
        chk_zero("t6");
        send_bits(16'h8001, 16);
        pulse_le();
        chk("t6_state", bus.sw_state, 16'h8001);
        chk("t6_err", bus.frame_err, 0);
        chk("t6_fcnt", bus.frame_cnt, 1);
        // bit counter saturation with a 70-bit overrun
        for (int i = 0; i < 70; i++) send_bit(i % 3 == 0, 2);
        repeat (4) tick();
        chk("sat_bitcnt", bus.bit_cnt, 63);
        pulse_le();
        chk("sat_state", bus.sw_state, 16'h9249);
        chk("sat_err", bus.frame_err, 1);
        chk("sat_fcnt", bus.frame_cnt, 2);
        repeat (4) tick();
        chk("pending_empty", pend.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
